// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_POWERUP,
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } lcd_state_e;

    // Power-on init sequence: 8-bit 2-line function set, display on,
    // clear, entry mode increment.
    localparam int LCD_INIT_LEN = 4;
    localparam logic [7:0] LCD_INIT_ROM [0:LCD_INIT_LEN-1] = '{
        8'h38,
        8'h0C,
        8'h01,
        8'h06
    };

    // Instructions that need the long execute time.
    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear and return-home (0x02 and its don't-care alias 0x03) are the
    // slow instructions; data writes never are, whatever the byte value.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == LCD_CMD_CLEAR) || (data[7:1] == LCD_CMD_HOME[7:1]));
    endfunction

endpackage

// File: rtl/lcd_sequencer.sv
// Character-LCD write sequencer: runs the power-on init sequence and then
// turns each accepted command/data byte into a timed setup/EN/hold/execute
// transfer on the LCD pins. One down-counter times every state.
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC = 750000,
    parameter int SETUP_CYC   = 2,
    parameter int EN_CYC      = 25,
    parameter int HOLD_CYC    = 1,
    parameter int EXEC_CYC    = 2000,
    parameter int CLEAR_CYC   = 82000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_cmd_valid,
    input  logic       i_cmd_rs,
    input  logic [7:0] i_cmd_data,
    output logic       o_cmd_ready,
    output logic       o_init_done,
    output logic       o_busy,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic       o_lcd_on
);

    localparam int MAX_CYC = max_int(max_int(max_int(POWERUP_CYC, SETUP_CYC),
                                             max_int(EN_CYC, HOLD_CYC)),
                                     max_int(EXEC_CYC, CLEAR_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int IDX_W   = $clog2(LCD_INIT_LEN);

    // The first power-up cycle is spent arming o_lcd_on while the counter
    // still holds its reset value of zero, so the remaining power-up wait
    // is loaded one shorter to keep the total at POWERUP_CYC cycles.
    localparam logic [CNT_W-1:0] LD_POWERUP = CNT_W'(POWERUP_CYC - 2);
    localparam logic [CNT_W-1:0] LD_SETUP   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EN      = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EXEC    = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LD_CLEAR   = CNT_W'(CLEAR_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(LCD_INIT_LEN - 1);

    lcd_state_e       state;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] init_idx;
    logic [IDX_W-1:0] next_idx;
    logic             count_done;
    logic             en_reg;
    logic             ready_reg;
    logic             done_reg;
    logic             on_reg;
    logic [7:0]       data_reg;
    logic             rs_reg;

    assign next_idx   = init_idx + IDX_W'(1);
    assign count_done = (count == '0);

    // Sequencer FSM: every timed state loads N-1 on entry and leaves on the
    // cycle the counter reads zero; all pin and handshake outputs are
    // registered here so they change only on state transitions.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state     <= S_POWERUP;
            count     <= '0;
            init_idx  <= '0;
            en_reg    <= 1'b0;
            ready_reg <= 1'b0;
            done_reg  <= 1'b0;
            on_reg    <= 1'b0;
            data_reg  <= 8'h00;
            rs_reg    <= 1'b0;
        end else begin
            on_reg <= 1'b1;
            unique case (state)
                S_POWERUP: begin
                    if (!on_reg) begin
                        count <= LD_POWERUP;
                    end else if (count_done) begin
                        data_reg <= LCD_INIT_ROM[0];
                        rs_reg   <= 1'b0;
                        count    <= LD_SETUP;
                        state    <= S_SETUP;
                    end else begin
                        count <= count - 1'b1;
                    end
                end

                S_IDLE: begin
                    if (i_cmd_valid) begin
                        data_reg  <= i_cmd_data;
                        rs_reg    <= i_cmd_rs;
                        ready_reg <= 1'b0;
                        count     <= LD_SETUP;
                        state     <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (count_done) begin
                        en_reg <= 1'b1;
                        count  <= LD_EN;
                        state  <= S_PULSE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end

                S_PULSE: begin
                    if (count_done) begin
                        en_reg <= 1'b0;
                        count  <= LD_HOLD;
                        state  <= S_HOLD;
                    end else begin
                        count <= count - 1'b1;
                    end
                end

                S_HOLD: begin
                    if (count_done) begin
                        count <= is_long_cmd(rs_reg, data_reg) ? LD_CLEAR : LD_EXEC;
                        state <= S_WAIT;
                    end else begin
                        count <= count - 1'b1;
                    end
                end

                S_WAIT: begin
                    if (count_done) begin
                        if (!done_reg && (init_idx != LAST_IDX)) begin
                            init_idx <= next_idx;
                            data_reg <= LCD_INIT_ROM[next_idx];
                            rs_reg   <= 1'b0;
                            count    <= LD_SETUP;
                            state    <= S_SETUP;
                        end else begin
                            done_reg  <= 1'b1;
                            ready_reg <= 1'b1;
                            state     <= S_IDLE;
                        end
                    end else begin
                        count <= count - 1'b1;
                    end
                end

                default: begin
                    en_reg    <= 1'b0;
                    ready_reg <= 1'b0;
                    count     <= '0;
                    state     <= S_POWERUP;
                end
            endcase
        end
    end

    // EN is gated with reset so a transfer aborts without waiting for the
    // flop to clear; everything else comes straight from registers.
    assign o_lcd_en    = en_reg & ~i_reset;
    assign o_lcd_data  = data_reg;
    assign o_lcd_rs    = rs_reg;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_on    = on_reg;
    assign o_cmd_ready = ready_reg;
    assign o_busy      = ~ready_reg;
    assign o_init_done = done_reg;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed testbench for lcd_sequencer with short timing parameters.
module tb_lcd_sequencer;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_rs;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       init_done;
    logic       busy;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic       lcd_on;

    int testsRun  = 0;
    int failCount = 0;
    int enRises   = 0;

    lcd_sequencer #(
        .POWERUP_CYC(10),
        .SETUP_CYC  (2),
        .EN_CYC     (3),
        .HOLD_CYC   (1),
        .EXEC_CYC   (5),
        .CLEAR_CYC  (8)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_cmd_valid(cmd_valid),
        .i_cmd_rs   (cmd_rs),
        .i_cmd_data (cmd_data),
        .o_cmd_ready(cmd_ready),
        .o_init_done(init_done),
        .o_busy     (busy),
        .o_lcd_data (lcd_data),
        .o_lcd_rs   (lcd_rs),
        .o_lcd_rw   (lcd_rw),
        .o_lcd_en   (lcd_en),
        .o_lcd_on   (lcd_on)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every EN pulse so stray or missing pulses show up in the total.
    always @(posedge lcd_en) enRises++;

    function automatic logic [7:0] bit8(input logic b);
        return {7'd0, b};
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic rs, input logic [7:0] data);
        cmd_valid = valid;
        cmd_rs    = rs;
        cmd_data  = data;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ":en"},    bit8(lcd_en),    8'd0);
        checkOutput({tag, ":on"},    bit8(lcd_on),    8'd0);
        checkOutput({tag, ":data"},  lcd_data,        8'h00);
        checkOutput({tag, ":rs"},    bit8(lcd_rs),    8'd0);
        checkOutput({tag, ":rw"},    bit8(lcd_rw),    8'd0);
        checkOutput({tag, ":ready"}, bit8(cmd_ready), 8'd0);
        checkOutput({tag, ":busy"},  bit8(busy),      8'd1);
        checkOutput({tag, ":done"},  bit8(init_done), 8'd0);
    endtask

    // Starts just after the edge that entered setup; ends just after the
    // edge that leaves the execute wait (2 + 3 + 1 + waitCyc edges later).
    task automatic transfer(input string tag, input logic [7:0] d, input logic r, input int waitCyc);
        checkOutput({tag, ":setup_data"}, lcd_data, d);
        checkOutput({tag, ":setup_rs"}, bit8(lcd_rs), bit8(r));
        checkOutput({tag, ":setup_en"}, bit8(lcd_en), 8'd0);
        checkOutput({tag, ":setup_ready"}, bit8(cmd_ready), 8'd0);
        checkOutput({tag, ":setup_busy"}, bit8(busy), 8'd1);
        stepCycles(1);
        checkOutput({tag, ":setup2_en"}, bit8(lcd_en), 8'd0);
        stepCycles(1);
        checkOutput({tag, ":rise_en"}, bit8(lcd_en), 8'd1);
        checkOutput({tag, ":rise_data"}, lcd_data, d);
        checkOutput({tag, ":rise_rs"}, bit8(lcd_rs), bit8(r));
        stepCycles(2);
        checkOutput({tag, ":pulse_last_en"}, bit8(lcd_en), 8'd1);
        stepCycles(1);
        checkOutput({tag, ":hold_en"}, bit8(lcd_en), 8'd0);
        checkOutput({tag, ":hold_data"}, lcd_data, d);
        stepCycles(1);
        checkOutput({tag, ":wait_en"}, bit8(lcd_en), 8'd0);
        stepCycles(waitCyc - 1);
        checkOutput({tag, ":wait_last_ready"}, bit8(cmd_ready), 8'd0);
        checkOutput({tag, ":wait_last_busy"}, bit8(busy), 8'd1);
        stepCycles(1);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);

        // Reset state, then release two units after an edge.
        stepCycles(2);
        checkResetValues("reset");
        #1 reset = 1'b0;

        // Power-up wait: LCD power on after the first edge, no EN yet.
        stepCycles(1);
        checkOutput("pwr_on", bit8(lcd_on), 8'd1);
        checkOutput("pwr_en", bit8(lcd_en), 8'd0);
        stepCycles(8);
        checkOutput("pwr_end_en", bit8(lcd_en), 8'd0);
        checkOutput("pwr_end_data", lcd_data, 8'h00);
        stepCycles(1);

        // Init sequence; first EN rises at edge 12 after release.
        transfer("init0", 8'h38, 1'b0, 5);
        transfer("init1", 8'h0C, 1'b0, 5);
        transfer("init2", 8'h01, 1'b0, 8);
        checkOutput("init3_done_low", bit8(init_done), 8'd0);
        transfer("init3", 8'h06, 1'b0, 5);
        checkOutput("init_done", bit8(init_done), 8'd1);
        checkOutput("init_ready", bit8(cmd_ready), 8'd1);
        checkOutput("init_busy", bit8(busy), 8'd0);
        checkOutput("init_en_rises", enRises[7:0], 8'd4);

        // Data byte 'A': 11 cycles from acceptance to ready.
        applyStimulus(1'b1, 1'b1, 8'h41);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        transfer("data41", 8'h41, 1'b1, 5);
        checkOutput("data41_ready", bit8(cmd_ready), 8'd1);
        stepCycles(2);
        checkOutput("idle_keep_data", lcd_data, 8'h41);
        checkOutput("idle_en", bit8(lcd_en), 8'd0);

        // Return-home instruction takes the long wait: 14 cycles.
        applyStimulus(1'b1, 1'b0, 8'h02);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        transfer("home", 8'h02, 1'b0, 8);
        checkOutput("home_ready", bit8(cmd_ready), 8'd1);

        // Data byte 0x01 is not a clear: short wait.
        applyStimulus(1'b1, 1'b1, 8'h01);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        transfer("data01", 8'h01, 1'b1, 5);
        checkOutput("data01_ready", bit8(cmd_ready), 8'd1);

        // Back-to-back with valid held: one idle cycle between transfers.
        applyStimulus(1'b1, 1'b1, 8'h48);
        stepCycles(1);
        applyStimulus(1'b1, 1'b1, 8'h49);
        transfer("b2b_48", 8'h48, 1'b1, 5);
        checkOutput("b2b_gap_ready", bit8(cmd_ready), 8'd1);
        checkOutput("b2b_gap_data", lcd_data, 8'h48);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        transfer("b2b_49", 8'h49, 1'b1, 5);
        checkOutput("b2b_end_ready", bit8(cmd_ready), 8'd1);
        stepCycles(3);
        checkOutput("b2b_no_dup_ready", bit8(cmd_ready), 8'd1);
        checkOutput("b2b_no_dup_data", lcd_data, 8'h49);

        // Valid pulsed during the EN pulse is ignored.
        applyStimulus(1'b1, 1'b1, 8'h55);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        stepCycles(2);
        checkOutput("ign_en_high", bit8(lcd_en), 8'd1);
        applyStimulus(1'b1, 1'b0, 8'h77);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkOutput("ign_data", lcd_data, 8'h55);
        stepCycles(8);
        checkOutput("ign_ready", bit8(cmd_ready), 8'd1);
        stepCycles(4);
        checkOutput("ign_no_extra_en", bit8(lcd_en), 8'd0);
        checkOutput("ign_final_data", lcd_data, 8'h55);
        checkOutput("ign_en_rises", enRises[7:0], 8'd10);

        // Reset in the middle of an EN pulse aborts at once.
        applyStimulus(1'b1, 1'b1, 8'h66);
        stepCycles(1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        stepCycles(3);
        checkOutput("abort_en_before", bit8(lcd_en), 8'd1);
        reset = 1'b1;
        #1;
        checkResetValues("abort");
        stepCycles(2);
        checkResetValues("abort_held");
        #1 reset = 1'b0;

        // Init restarts from the first ROM byte.
        stepCycles(10);
        checkOutput("restart_done", bit8(init_done), 8'd0);
        transfer("restart0", 8'h38, 1'b0, 5);
        checkOutput("restart_next", lcd_data, 8'h0C);
        checkOutput("total_en_rises", enRises[7:0], 8'd12);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/lcd_sequencer.md
Name: lcd_sequencer

Overview:
- Drives the character-LCD pins (HD44780-compatible, 8-bit mode, write-only) from a command/data stream.
- Runs a fixed power-on init sequence automatically, then accepts one byte per valid/ready handshake.
- Generates setup, enable-pulse, hold and execute timing from the single system clock.
- Sits between the memory-mapped LCD output register path and the LCD pins, so software no longer bit-bangs EN timing.

Parameters:
- POWERUP_CYC, 750000: cycles waited after reset before the first init command (15 ms at 50 MHz).
- SETUP_CYC, 2: cycles RS/DATA are stable before EN rises (minimum 1).
- EN_CYC, 25: cycles EN is held high (minimum 1).
- HOLD_CYC, 1: cycles RS/DATA are held after EN falls (minimum 1).
- EXEC_CYC, 2000: execute wait for normal commands and data (40 us).
- CLEAR_CYC, 82000: execute wait for clear (0x01) and home (0x02/0x03) commands (1.64 ms).

Ports:
- i_clk, input, 1: system clock.
- i_reset, input, 1: asynchronous, active-high reset.
- i_cmd_valid, input, 1: a command/data byte is offered.
- i_cmd_rs, input, 1: 0 = instruction, 1 = data.
- i_cmd_data, input, 8: byte to write.
- o_cmd_ready, output, 1: sequencer can accept a byte this cycle.
- o_init_done, output, 1: power-on init sequence has completed.
- o_busy, output, 1: a transfer or init is in progress.
- o_lcd_data, output, 8: LCD DB7..DB0.
- o_lcd_rs, output, 1: LCD RS.
- o_lcd_rw, output, 1: LCD RW, constant 0.
- o_lcd_en, output, 1: LCD E.
- o_lcd_on, output, 1: LCD power enable.

Behaviour:
- Reset (async, active-high) values:
  - o_lcd_data=0x00, o_lcd_rs=0, o_lcd_rw=0, o_lcd_en=0, o_lcd_on=0.
  - o_cmd_ready=0, o_init_done=0, o_busy=1.
  - FSM=S_POWERUP, counter=0, init index=0.
- Reset asserted mid-transfer aborts it immediately. EN drops combinationally with reset; outputs are registered otherwise.
- o_lcd_on: 1 from the first clock edge after reset release.
- States: S_POWERUP, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT.
- Counter:
  - Single down-counter, width $clog2 of the largest parameter + 1.
  - Loaded with N-1 on state entry; the state exits on the cycle the counter reads 0. Each timed state therefore lasts exactly N cycles.
- S_POWERUP:
  - Lasts POWERUP_CYC cycles.
  - Then loads init byte 0 (rs=0) into the transfer registers and goes to S_SETUP.
- Init ROM, in order: 0x38 (function set), 0x0C (display on), 0x01 (clear), 0x06 (entry mode).
- S_SETUP (SETUP_CYC cycles): o_lcd_rs and o_lcd_data driven from the captured byte; EN=0.
- S_PULSE (EN_CYC cycles): EN=1.
- S_HOLD (HOLD_CYC cycles): EN=0, data and RS unchanged.
- S_WAIT:
  - Lasts CLEAR_CYC cycles if the captured byte has rs=0 and data is 0x01, 0x02 or 0x03; otherwise EXEC_CYC cycles.
  - On exit during init, if the index is below 3: increment it, load the next ROM byte, go to S_SETUP.
  - On exit during init at index 3: set o_init_done=1 (sticky until reset), go to S_IDLE.
  - On exit after init: go to S_IDLE.
- S_IDLE:
  - o_cmd_ready=1, o_busy=0 (o_cmd_ready is 0 in every other state).
  - When i_cmd_valid=1, the byte is accepted on that edge: rs/data captured, next state S_SETUP.
  - Data pins keep their last value while idle.
- Handshake:
  - Acceptance happens only when valid and ready are both 1.
  - i_cmd_valid asserted while not ready is ignored and not queued. The requester holds it until it sees ready.
  - Back-to-back: with valid held high, the next byte is accepted on the first idle cycle.
- Latency:
  - Acceptance to EN rise: SETUP_CYC cycles.
  - Acceptance to next ready: SETUP_CYC+EN_CYC+HOLD_CYC+wait cycles.
- o_busy is exactly the inverse of o_cmd_ready.

Decomposition:
- Package lcd_pkg contains:
  - state enum lcd_state_e;
  - init ROM constants LCD_INIT_ROM[0:3] and LCD_INIT_LEN=4;
  - command codes LCD_CMD_CLEAR=0x01 and LCD_CMD_HOME=0x02.
- No sub-module. The timer is inline, because one shared down-counter serves all states.

Test Plan (parameters POWERUP=10, SETUP=2, EN=3, HOLD=1, EXEC=5, CLEAR=8):
- Reset release, no commands:
  - Four EN pulses carry data 0x38, 0x0C, 0x01, 0x06 with rs=0, each EN high exactly 3 cycles.
  - The first EN rises 12 cycles after reset release.
  - The wait after 0x01 is 8 cycles; after the others it is 5.
  - o_init_done rises and ready=1 after the last wait.
- After init, offer rs=1, data 0x41 held valid:
  - Accepted on the first cycle; EN rises 2 cycles later with o_lcd_data=0x41, rs=1.
  - Ready returns 11 cycles after acceptance.
- Offer rs=0, data 0x02: wait is 8 cycles, so ready returns 14 cycles after acceptance. Offer rs=1, data 0x01: wait is 5 cycles (data, not clear).
- Valid held high with bytes 0x48, 0x49 changed on each acceptance: two transfers with no lost or duplicated byte, and exactly one idle cycle between them.
- Valid pulsed during S_PULSE for one cycle: ignored, with no extra EN pulse.
- i_reset asserted in the middle of an EN pulse:
  - EN=0 immediately; all outputs return to their reset values.
  - After release, the full init sequence restarts from 0x38.
